// File: rtl/uart_write_arbiter_pkg.sv
// rtl/uart_write_arbiter_pkg.sv - shared types and constants for the UART write arbiter
package uart_write_arbiter_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/uart_write_arbiter_if.sv
// rtl/uart_write_arbiter_if.sv - thread request/data and serializer-side signals of the UART write arbiter
interface uart_write_arbiter_if;
   import uart_write_arbiter_pkg::*;

   logic              write_lock_req [1:0];
   logic              write_lock_res [1:0];
   logic [BYTE_W-1:0] data_in        [1:0];
   logic              data_in_valid  [1:0];
   logic              write_ready;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [15:0]       dropped_count;

   modport master (
      output write_lock_req, data_in, data_in_valid, tx_ready,
      input  write_lock_res, write_ready, tx_data, tx_valid, dropped_count
   );

   modport slave (
      input  write_lock_req, data_in, data_in_valid, tx_ready,
      output write_lock_res, write_ready, tx_data, tx_valid, dropped_count
   );

endinterface

// File: rtl/uart_write_arbiter_byte_fifo.sv
// rtl/uart_write_arbiter_byte_fifo.sv - byte FIFO with occupancy count; push and pop may coincide when full
module byte_fifo
   import uart_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [BYTE_W-1:0]      push_data_i,
   input  logic                   pop_i,
   output logic [BYTE_W-1:0]      pop_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/uart_write_arbiter.sv
// rtl/uart_write_arbiter.sv - two-thread UART write-lock arbiter feeding a shared TX byte FIFO
// Optional drop statistics: UART_WRITE_ARBITER_DROP_STATS_EN.
module uart_write_arbiter
   import uart_write_arbiter_pkg::*;
#(
   parameter int BUFFER_SIZE = 256
) (
   input  logic           clock,
   input  logic           reset,
   uart_write_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic              fifo_full, fifo_empty;
   logic [$clog2(BUFFER_SIZE):0] fifo_count;
   logic              push, pop, owner_valid, write_ready;
   logic [BYTE_W-1:0] push_data;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (bus.write_lock_req[0] && bus.write_lock_req[1]) begin
               state_d = last_q ? OWN0 : OWN1;
               last_d  = !last_q;
            end else if (bus.write_lock_req[0]) begin
               state_d = OWN0;
               last_d  = 1'b0;
            end else if (bus.write_lock_req[1]) begin
               state_d = OWN1;
               last_d  = 1'b1;
            end
         end
         OWN0:    if (!bus.write_lock_req[0]) state_d = IDLE;
         OWN1:    if (!bus.write_lock_req[1]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign bus.write_lock_res[0] = (state_q == OWN0);
   assign bus.write_lock_res[1] = (state_q == OWN1);

   always_comb begin
      owner_valid = 1'b0;
      push_data   = bus.data_in[0];
      if (state_q == OWN0) begin
         owner_valid = bus.data_in_valid[0];
      end else if (state_q == OWN1) begin
         owner_valid = bus.data_in_valid[1];
         push_data   = bus.data_in[1];
      end
   end

   assign pop             = !fifo_empty && bus.tx_ready;
   assign write_ready     = !fifo_full || pop;
   assign push            = owner_valid && write_ready;
   assign bus.write_ready = write_ready;
   assign bus.tx_valid    = !fifo_empty;

   byte_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .pop_data_o  (bus.tx_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assert property (@(posedge clock) disable iff (reset) fifo_empty == (fifo_count == '0));

`ifdef UART_WRITE_ARBITER_DROP_STATS_EN
   logic [15:0] drop_q, drop_d;
   logic        drop0, drop1;
   logic [16:0] drop_sum;

   // Both threads can be rejected in the same cycle, so the count may step by two.
   always_comb begin
      drop0    = bus.data_in_valid[0] && !(state_q == OWN0 && write_ready);
      drop1    = bus.data_in_valid[1] && !(state_q == OWN1 && write_ready);
      drop_sum = {1'b0, drop_q} + {16'd0, drop0} + {16'd0, drop1};
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clock) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_d;
   end

   assign bus.dropped_count = drop_q;
`else
   assign bus.dropped_count = '0;
`endif

endmodule

// File: tb/tb_uart_write_arbiter.sv
// tb/tb_uart_write_arbiter.sv - randomized and directed self-check of uart_write_arbiter against a queue model
module tb_uart_write_arbiter;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   uart_write_arbiter_if bus_if();

   uart_write_arbiter #(.BUFFER_SIZE(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   int         n_vec  = 0;
   int         n_miss = 0;
   bit         m_known = 0;
   logic [7:0] m_q [$];
   int         m_owner = -1;
   int         m_last  = 1;
   int         m_drop  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic rst, input logic [1:0] rq, input logic [1:0] dv,
                        input logic [7:0] d0, input logic [7:0] d1, input logic txr);
      int   sz;
      logic exp_wr;
      logic acc;
      int   ndrop;
      @(negedge clock);
      reset                     = rst;
      bus_if.write_lock_req[0]  = rq[0];
      bus_if.write_lock_req[1]  = rq[1];
      bus_if.data_in_valid[0]   = dv[0];
      bus_if.data_in_valid[1]   = dv[1];
      bus_if.data_in[0]         = d0;
      bus_if.data_in[1]         = d1;
      bus_if.tx_ready           = txr;
      #1;
      sz     = m_q.size();
      exp_wr = (sz < N) || (sz > 0 && txr);
      if (m_known) begin
         chk("res0", bus_if.write_lock_res[0], m_owner == 0);
         chk("res1", bus_if.write_lock_res[1], m_owner == 1);
         chk("tx_valid", bus_if.tx_valid, sz > 0);
         if (sz > 0) chk("tx_data", bus_if.tx_data, m_q[0]);
         chk("write_ready", bus_if.write_ready, exp_wr);
         chk("dropped", bus_if.dropped_count, m_drop);
      end
      if (rst) begin
         m_q.delete();
         m_owner = -1;
         m_last  = 1;
         m_drop  = 0;
         m_known = 1;
      end else begin
         acc   = (m_owner >= 0) && dv[m_owner] && exp_wr;
         ndrop = 0;
         for (int i = 0; i < 2; i++)
            if (dv[i] && !(m_owner == i && exp_wr)) ndrop++;
         if (sz > 0 && txr) void'(m_q.pop_front());
         if (acc) m_q.push_back(m_owner == 0 ? d0 : d1);
`ifdef UART_WRITE_ARBITER_DROP_STATS_EN
         m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
`else
         if (ndrop < 0) m_drop = 0;
`endif
         if (m_owner < 0) begin
            if (rq[0] && rq[1]) m_owner = (m_last == 0) ? 1 : 0;
            else if (rq[0])     m_owner = 0;
            else if (rq[1])     m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
         end else if (!rq[m_owner]) begin
            m_owner = -1;
         end
      end
   endtask

   initial begin
      logic [1:0] rq, dv;
      logic [7:0] d0, d1;
      logic       txr, rst;
      int         exp_d;

      cycle(1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
      cycle(1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
      chk("rst_res0", bus_if.write_lock_res[0], 0);
      chk("rst_res1", bus_if.write_lock_res[1], 0);
      chk("rst_txv", bus_if.tx_valid, 0);
      chk("rst_wr", bus_if.write_ready, 1);

      // Basic ownership and in-order delivery.
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 0);
      cycle(0, 2'b01, 2'b01, 8'hA5, 8'h00, 0);
      chk("own0", bus_if.write_lock_res[0], 1);
      cycle(0, 2'b01, 2'b01, 8'h3C, 8'h00, 0);
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 1);
      chk("first_a5", bus_if.tx_data, 8'hA5);
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 1);
      chk("second_3c", bus_if.tx_data, 8'h3C);
      cycle(0, 2'b00, 2'b00, 8'h00, 8'h00, 1);

      // Contention from reset, non-owner byte ignored, release then hand-over.
      cycle(1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
      cycle(0, 2'b11, 2'b00, 8'h00, 8'h00, 0);
      cycle(0, 2'b11, 2'b10, 8'h00, 8'h77, 0);
      chk("both_own0", bus_if.write_lock_res[0], 1);
      cycle(0, 2'b10, 2'b00, 8'h00, 8'h00, 0);
      chk("ignored_77", bus_if.tx_valid, 0);
      cycle(0, 2'b10, 2'b00, 8'h00, 8'h00, 0);
      chk("gap_idle", bus_if.write_lock_res[1], 0);
      cycle(0, 2'b10, 2'b00, 8'h00, 8'h00, 0);
      chk("own1", bus_if.write_lock_res[1], 1);

      // Fill to full, drop the fifth, then push and pop together while full.
      cycle(1, 2'b00, 2'b00, 8'h00, 8'h00, 0);
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(0, 2'b01, 2'b01, 8'h10 + 8'(k), 8'h00, 0);
         if (k == 4) chk("full_ready", bus_if.write_ready, 0);
      end
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 0);
`ifdef UART_WRITE_ARBITER_DROP_STATS_EN
      exp_d = 1;
`else
      exp_d = 0;
`endif
      chk("drop_count", bus_if.dropped_count, exp_d);
      cycle(0, 2'b01, 2'b01, 8'h20, 8'h00, 1);
      chk("full_pass_ready", bus_if.write_ready, 1);
      cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 0);
      chk("still_full", bus_if.write_ready, 0);
      for (int k = 0; k < 5; k++) cycle(0, 2'b01, 2'b00, 8'h00, 8'h00, 1);

      // Reset while owning with bytes queued.
      cycle(0, 2'b10, 2'b00, 8'h00, 8'h00, 0);
      for (int k = 0; k < 4; k++) cycle(0, 2'b10, {1'b1, 1'b0}, 8'h00, 8'h40 + 8'(k), 0);
      cycle(1, 2'b10, 2'b00, 8'h00, 8'h00, 0);
      cycle(0, 2'b00, 2'b00, 8'h00, 8'h00, 0);
      chk("rst_mid_res1", bus_if.write_lock_res[1], 0);
      chk("rst_mid_txv", bus_if.tx_valid, 0);
      chk("rst_mid_wr", bus_if.write_ready, 1);

      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(0, 299) == 0);
         rq[0] = ($urandom_range(0, 9) < 7);
         rq[1] = ($urandom_range(0, 9) < 7);
         dv[0] = $urandom_range(0, 1) == 1;
         dv[1] = $urandom_range(0, 1) == 1;
         d0    = 8'($urandom_range(0, 255));
         d1    = 8'($urandom_range(0, 255));
         txr   = ($urandom_range(0, 2) == 0);
         cycle(rst, rq, dv, d0, d1, txr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
